// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM responder: command encodings, mode
// register field positions, error codes and the per-bank state type.
// Optional checker macro used by the design: SDRAM_RESPONDER_CHECK_EN.
package sdram_pkg;

    // Command word is {cs, ras, cas, we}
    localparam logic [3:0] CMD_LOAD_MODE    = 4'b0000;
    localparam logic [3:0] CMD_AUTO_REFRESH = 4'b0001;
    localparam logic [3:0] CMD_PRECHARGE    = 4'b0010;
    localparam logic [3:0] CMD_ACTIVE       = 4'b0011;
    localparam logic [3:0] CMD_WRITE        = 4'b0100;
    localparam logic [3:0] CMD_READ         = 4'b0101;
    localparam logic [3:0] CMD_BURST_TERM   = 4'b0110;
    localparam logic [3:0] CMD_NOP          = 4'b0111;
    localparam logic [3:0] CMD_INHIBIT      = 4'b1111;

    // Mode register field positions
    localparam int MODE_BL_LSB = 0;
    localparam int MODE_BL_MSB = 2;
    localparam int MODE_CL_LSB = 4;
    localparam int MODE_CL_MSB = 6;

    typedef enum logic [3:0] {
        ERR_NONE         = 4'd0,
        ERR_IDLE_ACCESS  = 4'd1,
        ERR_TRCD         = 4'd2,
        ERR_ACT_NOT_IDLE = 4'd3,
        ERR_REF_NOT_IDLE = 4'd4,
        ERR_NO_MODE      = 4'd5,
        ERR_BAD_MODE     = 4'd6,
        ERR_LM_NOT_IDLE  = 4'd7
    } err_e;

    typedef enum logic [1:0] {
        BANK_IDLE    = 2'd0,
        BANK_OPENING = 2'd1,
        BANK_OPEN    = 2'd2
    } bank_state_e;

    // A mode word is legal only with burst length 1 and CL of 2 or 3
    function automatic logic mode_ok(input logic [12:0] mode);
        logic [2:0] cl;
        cl = mode[MODE_CL_MSB:MODE_CL_LSB];
        return (mode[MODE_BL_MSB:MODE_BL_LSB] == 3'd0) &&
               ((cl == 3'd2) || (cl == 3'd3));
    endfunction

endpackage

// File: rtl/sdram_responder_if.sv
// SDRAM command/data bus between the controller (master) and the
// responder (slave).
interface sdram_responder_if;
    logic        sd_cs;
    logic        sd_ras;
    logic        sd_cas;
    logic        sd_we;
    logic [12:0] sd_addr;
    logic [1:0]  sd_ba;
    logic [1:0]  sd_dqm;
    logic [15:0] sd_data_in;
    logic [15:0] sd_data_out;
    logic        sd_data_oe;

    modport master (
        output sd_cs, sd_ras, sd_cas, sd_we, sd_addr, sd_ba, sd_dqm, sd_data_in,
        input  sd_data_out, sd_data_oe
    );

    modport slave (
        input  sd_cs, sd_ras, sd_cas, sd_we, sd_addr, sd_ba, sd_dqm, sd_data_in,
        output sd_data_out, sd_data_oe
    );
endinterface

// File: rtl/sdram_bank_fsm.sv
// One SDRAM bank: IDLE/OPENING/OPEN state, latched row and tRCD countdown.
// With SDRAM_RESPONDER_CHECK_EN defined it also reports bank-local
// protocol errors for the command currently on the bus.
module sdram_bank_fsm
    import sdram_pkg::*;
#(
    parameter int ROW_BITS = 4,
    parameter int TRCD     = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sel,
    input  logic [3:0]          cmd,
    input  logic                a10,
    input  logic [ROW_BITS-1:0] row_in,
    output bank_state_e         state,
    output logic [ROW_BITS-1:0] open_row
`ifdef SDRAM_RESPONDER_CHECK_EN
    ,
    output logic [3:0]          err
`endif
);

    // Loaded on ACTIVE; the bank opens on the edge where it would reach zero,
    // so an access at E_active+TRCD sees OPEN.
    localparam logic [7:0] TRCD_LOAD = (TRCD > 1) ? 8'(TRCD - 1) : 8'd0;

    bank_state_e         state_r;
    logic [ROW_BITS-1:0] row_r;
    logic [7:0]          cnt_r;
    logic                is_access_s;

    assign is_access_s = (cmd == CMD_READ) || (cmd == CMD_WRITE);
    assign state       = state_r;
    assign open_row    = row_r;

    // Bank state machine: open, count down tRCD, close on precharge/auto-precharge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= BANK_IDLE;
            row_r   <= '0;
            cnt_r   <= 8'd0;
        end else if ((cmd == CMD_PRECHARGE) && (a10 || sel)) begin
            state_r <= BANK_IDLE;
            cnt_r   <= 8'd0;
        end else if (sel && (cmd == CMD_ACTIVE)) begin
            state_r <= (TRCD > 1) ? BANK_OPENING : BANK_OPEN;
            row_r   <= row_in;
            cnt_r   <= TRCD_LOAD;
        end else if (sel && is_access_s && a10) begin
            state_r <= BANK_IDLE;
            cnt_r   <= 8'd0;
        end else if (state_r == BANK_OPENING) begin
            if (cnt_r <= 8'd1) begin
                state_r <= BANK_OPEN;
                cnt_r   <= 8'd0;
            end else begin
                cnt_r   <= cnt_r - 8'd1;
            end
        end else begin
            state_r <= state_r;
        end
    end

`ifdef SDRAM_RESPONDER_CHECK_EN
    // Bank-local error classification of the current command
    always_comb begin
        err = ERR_NONE;
        if (sel && is_access_s) begin
            case (state_r)
                BANK_IDLE:    err = ERR_IDLE_ACCESS;
                BANK_OPENING: err = ERR_TRCD;
                default:      err = ERR_NONE;
            endcase
        end else if (sel && (cmd == CMD_ACTIVE) && (state_r != BANK_IDLE)) begin
            err = ERR_ACT_NOT_IDLE;
        end else begin
            err = ERR_NONE;
        end
    end
`endif

endmodule

// File: rtl/sdram_responder.sv
// SDRAM device model for the picosoc controller: command decode, mode
// register, reduced-depth array, CAS-latency read pipeline, refresh counter.
// Define SDRAM_RESPONDER_CHECK_EN to compile in the protocol checker that
// drives err_code; otherwise err_code is tied to zero.
module sdram_responder
    import sdram_pkg::*;
#(
    parameter int ROW_BITS = 4,
    parameter int COL_BITS = 8,
    parameter int TRCD     = 3
) (
    input  logic             clk,
    input  logic             reset,
    sdram_responder_if.slave bus,
    output logic [15:0]      refresh_cnt,
    output logic [3:0]       err_code
);

    localparam int AW    = 2 + ROW_BITS + COL_BITS;
    localparam int DEPTH = 1 << AW;

    logic [3:0]          cmd_s;
    logic                is_rd_s;
    logic                is_wr_s;
    bank_state_e         bank_state_s [4];
    logic [ROW_BITS-1:0] bank_row_s [4];
    logic [AW-1:0]       idx_s;
    logic [15:0]         rd_data_s;
    logic                cl2_s;

    logic [2:0]          mode_cl_r;
    logic [15:0]         refresh_cnt_r;
    logic [15:0]         mem_r [DEPTH];

    // Read pipeline: stage0 only used for CL=3, stage1 feeds the output register
    logic                p0_v_r;
    logic [15:0]         p0_d_r;
    logic                p1_v_r;
    logic [15:0]         p1_d_r;
    logic [15:0]         data_out_r;
    logic                data_oe_r;

    assign cmd_s   = {bus.sd_cs, bus.sd_ras, bus.sd_cas, bus.sd_we};
    assign is_rd_s = (cmd_s == CMD_READ);
    assign is_wr_s = (cmd_s == CMD_WRITE);
    assign cl2_s   = (mode_cl_r == 3'd2);

`ifdef SDRAM_RESPONDER_CHECK_EN
    logic [3:0] bank_err_s [4];
`endif

    for (genvar g = 0; g < 4; g++) begin : g_bank
        sdram_bank_fsm #(
            .ROW_BITS (ROW_BITS),
            .TRCD     (TRCD)
        ) u_bank (
            .clk      (clk),
            .reset    (reset),
            .sel      (bus.sd_ba == 2'(g)),
            .cmd      (cmd_s),
            .a10      (bus.sd_addr[10]),
            .row_in   (bus.sd_addr[ROW_BITS-1:0]),
            .state    (bank_state_s[g]),
            .open_row (bank_row_s[g])
`ifdef SDRAM_RESPONDER_CHECK_EN
            ,
            .err      (bank_err_s[g])
`endif
        );
    end

    assign idx_s     = {bus.sd_ba, bank_row_s[bus.sd_ba], bus.sd_addr[COL_BITS-1:0]};
    assign rd_data_s = mem_r[idx_s];

    // Array write with per-byte masks; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (is_wr_s) begin
            if (!bus.sd_dqm[1]) mem_r[idx_s][15:8] <= bus.sd_data_in[15:8];
            if (!bus.sd_dqm[0]) mem_r[idx_s][7:0]  <= bus.sd_data_in[7:0];
        end
    end

    // Mode register CAS-latency field and refresh counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_cl_r     <= 3'd0;
            refresh_cnt_r <= 16'h0;
        end else begin
            if (cmd_s == CMD_LOAD_MODE) mode_cl_r <= bus.sd_addr[MODE_CL_MSB:MODE_CL_LSB];
            if (cmd_s == CMD_AUTO_REFRESH) refresh_cnt_r <= refresh_cnt_r + 16'd1;
        end
    end

    // Read pipeline: data captured at the command edge, shown at E0+CL-1 for one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p0_v_r     <= 1'b0;
            p0_d_r     <= 16'h0;
            p1_v_r     <= 1'b0;
            p1_d_r     <= 16'h0;
            data_out_r <= 16'h0;
            data_oe_r  <= 1'b0;
        end else begin
            p0_v_r <= is_rd_s && !cl2_s;
            p0_d_r <= (is_rd_s && !cl2_s) ? rd_data_s : 16'h0;
            if (is_rd_s && cl2_s) begin
                p1_v_r <= 1'b1;
                p1_d_r <= rd_data_s;
            end else begin
                p1_v_r <= p0_v_r;
                p1_d_r <= p0_d_r;
            end
            data_out_r <= p1_v_r ? p1_d_r : 16'h0;
            data_oe_r  <= p1_v_r;
        end
    end

    assign bus.sd_data_out = data_out_r;
    assign bus.sd_data_oe  = data_oe_r;
    assign refresh_cnt     = refresh_cnt_r;

`ifdef SDRAM_RESPONDER_CHECK_EN
    logic       mode_valid_r;
    logic       any_busy_s;
    logic [3:0] new_err_s;
    logic [3:0] err_code_r;

    assign any_busy_s = (bank_state_s[0] != BANK_IDLE) || (bank_state_s[1] != BANK_IDLE) ||
                        (bank_state_s[2] != BANK_IDLE) || (bank_state_s[3] != BANK_IDLE);

    // Classify the current command; bank-local errors take precedence
    always_comb begin
        new_err_s = ERR_NONE;
        if (bank_err_s[bus.sd_ba] != ERR_NONE) begin
            new_err_s = bank_err_s[bus.sd_ba];
        end else if ((is_rd_s || is_wr_s || (cmd_s == CMD_ACTIVE)) && !mode_valid_r) begin
            new_err_s = ERR_NO_MODE;
        end else if ((cmd_s == CMD_AUTO_REFRESH) && any_busy_s) begin
            new_err_s = ERR_REF_NOT_IDLE;
        end else if ((cmd_s == CMD_LOAD_MODE) && any_busy_s) begin
            new_err_s = ERR_LM_NOT_IDLE;
        end else if ((cmd_s == CMD_LOAD_MODE) && !mode_ok(bus.sd_addr)) begin
            new_err_s = ERR_BAD_MODE;
        end else begin
            new_err_s = ERR_NONE;
        end
    end

    // Sticky first-error latch and mode-loaded flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_code_r   <= ERR_NONE;
            mode_valid_r <= 1'b0;
        end else begin
            if (cmd_s == CMD_LOAD_MODE) mode_valid_r <= 1'b1;
            if (err_code_r == ERR_NONE) err_code_r <= new_err_s;
        end
    end

    assign err_code = err_code_r;
`else
    assign err_code = ERR_NONE;
`endif

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder with a read-data scoreboard.
// Expected err_code values depend on SDRAM_RESPONDER_CHECK_EN.
module tb_sdram_responder;
    import sdram_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] refresh_cnt;
    logic [3:0]  err_code;

    sdram_responder_if bus();

    sdram_responder #(
        .ROW_BITS (4),
        .COL_BITS (8),
        .TRCD     (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .refresh_cnt (refresh_cnt),
        .err_code    (err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [15:0] data;
    } sb_t;

    sb_t sb[$];
    int  tests = 0;
    int  fails = 0;
    int  cyc   = 0;
    int  cl_b  = 3;

    function automatic logic [15:0] exp_err(input logic [3:0] c);
`ifdef SDRAM_RESPONDER_CHECK_EN
        return {12'd0, c};
`else
        return 16'd0 & {12'd0, c};
`endif
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock edge, then compare read outputs against the scoreboard
    task automatic tick();
        logic        e_oe;
        logic [15:0] e_d;
        @(posedge clk);
        cyc++;
        #1;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e_oe = 1'b1;
            e_d  = sb[0].data;
            void'(sb.pop_front());
        end else begin
            e_oe = 1'b0;
            e_d  = 16'h0;
        end
        check("data_oe", {15'd0, bus.sd_data_oe}, {15'd0, e_oe});
        check("data_out", bus.sd_data_out, e_d);
    endtask

    task automatic issue(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] addr,
                         input logic [1:0] dqm, input logic [15:0] din);
        {bus.sd_cs, bus.sd_ras, bus.sd_cas, bus.sd_we} = c;
        bus.sd_ba      = ba;
        bus.sd_addr    = addr;
        bus.sd_dqm     = dqm;
        bus.sd_data_in = din;
        tick();
        {bus.sd_cs, bus.sd_ras, bus.sd_cas, bus.sd_we} = CMD_NOP;
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) issue(CMD_NOP, 2'd0, 13'h0, 2'b00, 16'h0);
    endtask

    task automatic rd(input logic [1:0] ba, input logic [12:0] addr, input logic [15:0] exp);
        issue(CMD_READ, ba, addr, 2'b00, 16'h0);
        sb.push_back('{cyc + cl_b - 1, exp});
    endtask

    initial begin
        {bus.sd_cs, bus.sd_ras, bus.sd_cas, bus.sd_we} = CMD_NOP;
        bus.sd_ba      = 2'd0;
        bus.sd_addr    = 13'h0;
        bus.sd_dqm     = 2'b00;
        bus.sd_data_in = 16'h0;
        reset          = 1'b1;
        nop(2);
        check("reset_refresh", refresh_cnt, 16'h0);
        check("reset_err", {12'd0, err_code}, 16'h0);
        reset = 1'b0;

        // Init, seed bank 2, then the BEEF write/read sequence (CL=3)
        issue(CMD_PRECHARGE, 2'd0, 13'h400, 2'b00, 16'h0);
        issue(CMD_LOAD_MODE, 2'd0, 13'h0230, 2'b00, 16'h0);
        cl_b = 3;
        issue(CMD_ACTIVE, 2'd2, 13'd0, 2'b00, 16'h0);
        nop(2);
        issue(CMD_WRITE, 2'd2, 13'h400, 2'b00, 16'hC0DE);
        issue(CMD_ACTIVE, 2'd1, 13'd3, 2'b00, 16'h0);
        nop(2);
        issue(CMD_WRITE, 2'd1, 13'h405, 2'b00, 16'hBEEF);
        issue(CMD_ACTIVE, 2'd1, 13'd3, 2'b00, 16'h0);
        nop(2);
        rd(2'd1, 13'd5, 16'hBEEF);
        nop(3);
        check("init_err", {12'd0, err_code}, 16'h0);

        // Byte masks, write-then-read next cycle, back-to-back CL=3 reads
        issue(CMD_WRITE, 2'd1, 13'd6, 2'b00, 16'h1234);
        issue(CMD_WRITE, 2'd1, 13'd6, 2'b01, 16'hABCD);
        rd(2'd1, 13'd6, 16'hAB34);
        issue(CMD_WRITE, 2'd1, 13'd7, 2'b00, 16'h1234);
        issue(CMD_WRITE, 2'd1, 13'd7, 2'b10, 16'h5678);
        rd(2'd1, 13'd7, 16'h1278);
        issue(CMD_WRITE, 2'd1, 13'd8, 2'b00, 16'h0F0F);
        rd(2'd1, 13'd8, 16'h0F0F);
        rd(2'd1, 13'd5, 16'hBEEF);
        rd(2'd1, 13'd6, 16'hAB34);
        nop(4);

        // CL=2: single and back-to-back reads
        issue(CMD_PRECHARGE, 2'd0, 13'h400, 2'b00, 16'h0);
        issue(CMD_LOAD_MODE, 2'd0, 13'h0220, 2'b00, 16'h0);
        cl_b = 2;
        issue(CMD_ACTIVE, 2'd1, 13'd3, 2'b00, 16'h0);
        nop(2);
        rd(2'd1, 13'd5, 16'hBEEF);
        nop(2);
        rd(2'd1, 13'd5, 16'hBEEF);
        rd(2'd1, 13'd7, 16'h1278);
        nop(3);
        check("cl2_err", {12'd0, err_code}, 16'h0);

        // Refresh with all banks idle
        issue(CMD_PRECHARGE, 2'd0, 13'h400, 2'b00, 16'h0);
        issue(CMD_AUTO_REFRESH, 2'd0, 13'h0, 2'b00, 16'h0);
        issue(CMD_AUTO_REFRESH, 2'd0, 13'h0, 2'b00, 16'h0);
        issue(CMD_AUTO_REFRESH, 2'd0, 13'h0, 2'b00, 16'h0);
        nop(1);
        check("refresh_cnt3", refresh_cnt, 16'd3);
        check("refresh_err", {12'd0, err_code}, 16'h0);

        // tRCD violation (write still applied), then sticky on an idle-bank read
        issue(CMD_ACTIVE, 2'd0, 13'd1, 2'b00, 16'h0);
        nop(1);
        issue(CMD_WRITE, 2'd0, 13'd9, 2'b00, 16'h5A5A);
        check("trcd_err", {12'd0, err_code}, exp_err(4'd2));
        rd(2'd0, 13'd9, 16'h5A5A);
        nop(2);
        rd(2'd2, 13'd0, 16'hC0DE);
        nop(2);
        check("sticky_err", {12'd0, err_code}, exp_err(4'd2));

        // Reset one cycle after a READ flushes it
        rd(2'd0, 13'd9, 16'h5A5A);
        reset = 1'b1;
        sb.delete();
        #1;
        check("rst_data", bus.sd_data_out, 16'h0);
        check("rst_oe", {15'd0, bus.sd_data_oe}, 16'h0);
        check("rst_refresh", refresh_cnt, 16'h0);
        check("rst_err", {12'd0, err_code}, 16'h0);
        nop(2);
        reset = 1'b0;

        // Data survives reset; refresh with a bank open
        issue(CMD_LOAD_MODE, 2'd0, 13'h0230, 2'b00, 16'h0);
        cl_b = 3;
        issue(CMD_ACTIVE, 2'd0, 13'd1, 2'b00, 16'h0);
        nop(2);
        rd(2'd0, 13'd9, 16'h5A5A);
        nop(3);
        check("post_rst_err", {12'd0, err_code}, 16'h0);
        issue(CMD_AUTO_REFRESH, 2'd0, 13'h0, 2'b00, 16'h0);
        nop(1);
        check("refresh_cnt1", refresh_cnt, 16'd1);
        check("ref_open_err", {12'd0, err_code}, exp_err(4'd4));

        check("sb_drained", 16'(sb.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
